// File: rtl/x_micro_seq_engine.sv
// rtl/x_micro_seq_engine.sv - micro-sequencer with program RAM: OUT, WAIT, JUMP, counted LOOP, END
// Optional trace ports (o_pc, o_exec, o_cmd) are enabled by defining X_MICRO_SEQ_TRACE_EN.
module x_micro_seq_engine #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 9,
  parameter int LOOP_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_stop,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_wen,
  input  logic [3:0]        i_wcmd,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_waddr,
`ifdef X_MICRO_SEQ_TRACE_EN
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_exec,
  output logic [3:0]        o_cmd,
`endif
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_OUT  = 4'd1;
  localparam logic [3:0] C_WAIT = 4'd2;
  localparam logic [3:0] C_JUMP = 4'd3;
  localparam logic [3:0] C_LOOP = 4'd4;
  localparam logic [3:0] C_END  = 4'd5;

  logic [DATA_W+3:0] mem [2**ADDR_W];
  logic [DATA_W+3:0] rd_word;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [LOOP_W-1:0] loop_cnt;
  logic [LOOP_W-1:0] wait_cnt;

  logic [3:0]        cmd;
  logic [DATA_W-1:0] operand;
  logic [LOOP_W-1:0] wait_n;
  logic [ADDR_W-1:0] loop_target;
  logic [LOOP_W-1:0] loop_count;
  logic [ADDR_W-1:0] pc_next;

  assign cmd         = rd_word[DATA_W+3:DATA_W];
  assign operand     = rd_word[DATA_W-1:0];
  assign wait_n      = operand[LOOP_W-1:0];
  assign loop_target = operand[ADDR_W-1:0];
  assign loop_count  = operand[ADDR_W+LOOP_W-1:ADDR_W];
  assign pc_next     = pc + ADDR_W'(1);
  assign o_busy      = (state != S_IDLE);

`ifdef X_MICRO_SEQ_TRACE_EN
  assign o_pc = pc;
`endif

  // Program RAM: writes only while idle; read port always follows pc, one cycle latency
  always_ff @(posedge i_clk) begin
    if (i_wen && state == S_IDLE) begin
      mem[i_waddr] <= {i_wcmd, i_wdata};
    end
    rd_word <= mem[pc];
  end

  // Sequencer FSM: fetch/execute loop with stop taking priority over any action
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      loop_cnt <= '0;
      wait_cnt <= '0;
      o_done   <= 1'b0;
      o_data   <= '0;
      o_valid  <= 1'b0;
`ifdef X_MICRO_SEQ_TRACE_EN
      o_exec   <= 1'b0;
      o_cmd    <= 4'd0;
`endif
    end else begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;
`ifdef X_MICRO_SEQ_TRACE_EN
      o_exec  <= 1'b0;
`endif
      if (state != S_IDLE && i_stop) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              pc       <= i_start_addr;
              loop_cnt <= '0;
              state    <= S_FETCH;
            end
          end
          S_FETCH: begin
            state <= S_EXEC;
          end
          S_EXEC: begin
`ifdef X_MICRO_SEQ_TRACE_EN
            o_exec <= 1'b1;
            o_cmd  <= cmd;
`endif
            state <= S_FETCH;
            case (cmd)
              C_OUT: begin
                o_data  <= operand;
                o_valid <= 1'b1;
                pc      <= pc_next;
              end
              C_WAIT: begin
                if (wait_n == '0) begin
                  pc <= pc_next;
                end else begin
                  wait_cnt <= wait_n;
                  state    <= S_WAIT;
                end
              end
              C_JUMP: begin
                pc <= loop_target;
              end
              C_LOOP: begin
                if (loop_cnt < loop_count) begin
                  loop_cnt <= loop_cnt + LOOP_W'(1);
                  pc       <= loop_target;
                end else begin
                  loop_cnt <= '0;
                  pc       <= pc_next;
                end
              end
              C_END: begin
                state  <= S_IDLE;
                o_done <= 1'b1;
              end
              default: begin
                pc <= pc_next;
              end
            endcase
          end
          S_WAIT: begin
            wait_cnt <= wait_cnt - LOOP_W'(1);
            if (wait_cnt == LOOP_W'(1)) begin
              pc    <= pc_next;
              state <= S_FETCH;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_x_micro_seq_engine.sv
// tb/tb_x_micro_seq_engine.sv - directed self-checking bench for x_micro_seq_engine
module tb_x_micro_seq_engine;

  localparam int DATA_W = 36;
  localparam int ADDR_W = 9;
  localparam int LOOP_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              stop = 1'b0;
  logic              busy;
  logic              done;
  logic              wen = 1'b0;
  logic [3:0]        wcmd = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [DATA_W-1:0] data;
  logic              valid;
`ifdef X_MICRO_SEQ_TRACE_EN
  logic [ADDR_W-1:0] tr_pc;
  logic              tr_exec;
  logic [3:0]        tr_cmd;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int                nval;
  int                done_cyc;
  int                vcyc  [16];
  logic [DATA_W-1:0] vdata [16];
  int                ev;

  always #5 clk = ~clk;

  x_micro_seq_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOOP_W(LOOP_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_addr(start_addr),
    .i_stop(stop), .o_busy(busy), .o_done(done), .i_wen(wen), .i_wcmd(wcmd),
    .i_wdata(wdata), .i_waddr(waddr),
`ifdef X_MICRO_SEQ_TRACE_EN
    .o_pc(tr_pc), .o_exec(tr_exec), .o_cmd(tr_cmd),
`endif
    .o_data(data), .o_valid(valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [3:0] c, input logic [DATA_W-1:0] d);
    @(negedge clk);
    wen = 1'b1; waddr = a; wcmd = c; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Pulse start, then record o_valid/o_done events by cycle index (cycle 1 = first after start edge)
  task automatic run(input logic [ADDR_W-1:0] a, input int budget);
    int cyc;
    @(negedge clk);
    start = 1'b1; start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; nval = 0; done_cyc = -1;
    while (cyc <= budget) begin
      if (valid && nval < 16) begin
        vcyc[nval] = cyc; vdata[nval] = data; nval++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_busy",  64'(busy),  64'd0);
    check_eq("rst_done",  64'(done),  64'd0);
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_data",  64'(data),  64'd0);

    // OUT then END
    wr(9'd0, 4'd1, 36'h123);
    wr(9'd1, 4'd5, 36'h0);
    run(9'd0, 50);
    check_eq("p1_nval",  64'(nval), 64'd1);
    check_eq("p1_vcyc",  64'(vcyc[0]), 64'd3);
    check_eq("p1_data",  64'(vdata[0]), 64'h123);
    check_eq("p1_done",  64'(done_cyc), 64'd5);
    check_eq("p1_busy",  64'(busy), 64'd0);

    // OUT, WAIT 5, OUT, END
    wr(9'd2, 4'd1, 36'hA);
    wr(9'd3, 4'd2, 36'd5);
    wr(9'd4, 4'd1, 36'hB);
    wr(9'd5, 4'd5, 36'h0);
    run(9'd2, 100);
    check_eq("p2_nval",  64'(nval), 64'd2);
    check_eq("p2_gap",   64'(vcyc[1] - vcyc[0]), 64'd9);
    check_eq("p2_d0",    64'(vdata[0]), 64'hA);
    check_eq("p2_d1",    64'(vdata[1]), 64'hB);
    check_eq("p2_done",  64'(done_cyc), 64'd14);

    // counted loop: body runs count+1 = 4 times
    wr(9'd10, 4'd1, 36'd1);
    wr(9'd11, 4'd4, 36'h60A);
    wr(9'd12, 4'd5, 36'h0);
    run(9'd10, 100);
    check_eq("lp_nval",  64'(nval), 64'd4);
    check_eq("lp_vcyc3", 64'(vcyc[3]), 64'd15);
    check_eq("lp_done",  64'(done_cyc), 64'd19);

    // pc wraps 511 -> 0
    wr(9'd511, 4'd1, 36'd7);
    wr(9'd0, 4'd5, 36'h0);
    run(9'd511, 50);
    check_eq("wr_nval",  64'(nval), 64'd1);
    check_eq("wr_data",  64'(vdata[0]), 64'd7);
    check_eq("wr_done",  64'(done_cyc), 64'd5);

    // JUMP to END
    wr(9'd30, 4'd3, 36'd20);
    wr(9'd20, 4'd5, 36'h0);
    run(9'd30, 50);
    check_eq("jp_nval",  64'(nval), 64'd0);
    check_eq("jp_done",  64'(done_cyc), 64'd5);

    // long WAIT, write while busy, then stop
    wr(9'd40, 4'd2, 36'd1000);
    wr(9'd41, 4'd1, 36'h55);
    wr(9'd42, 4'd5, 36'h0);
    @(negedge clk);
    start = 1'b1; start_addr = 9'd40;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    wen = 1'b1; waddr = 9'd41; wcmd = 4'd1; wdata = 36'h99;
    repeat (2) @(negedge clk);
    wen = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("st_busy_pre", 64'(busy), 64'd1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check_eq("st_busy",  64'(busy), 64'd0);
    check_eq("st_done",  64'(done), 64'd0);
    check_eq("st_valid", 64'(valid), 64'd0);
    check_eq("st_data",  64'(data), 64'd7);
    ev = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || valid || busy) ev++;
    end
    check_eq("st_quiet", 64'(ev), 64'd0);
    run(9'd41, 50);
    check_eq("bw_nval",  64'(nval), 64'd1);
    check_eq("bw_data",  64'(vdata[0]), 64'h55);
    check_eq("bw_done",  64'(done_cyc), 64'd5);

    // async reset mid-loop, then rerun from retained RAM
    @(negedge clk);
    start = 1'b1; start_addr = 9'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("ar_pre_data", 64'(data), 64'd1);
    check_eq("ar_pre_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_busy",  64'(busy), 64'd0);
    check_eq("ar_data",  64'(data), 64'd0);
    check_eq("ar_valid", 64'(valid), 64'd0);
    check_eq("ar_done",  64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("ar_idle",  64'(busy), 64'd0);
    run(9'd10, 100);
    check_eq("ar_nval",  64'(nval), 64'd4);
    check_eq("ar_vcyc0", 64'(vcyc[0]), 64'd3);
    check_eq("ar_vcyc3", 64'(vcyc[3]), 64'd15);
    check_eq("ar_data3", 64'(vdata[3]), 64'd1);
    check_eq("ar_done_c", 64'(done_cyc), 64'd19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/x_micro_seq_engine.md
Name: x_micro_seq_engine

Overview:
Parametrised micro-sequencer with an internal program RAM. Each word holds a 4-bit command and a DATA_W-bit operand.
- Idle: host loads programs through the write port.
- On start: the block executes the program from a given address and emits data words, timed waits, jumps and a single-level counted loop until END or abort.
- Sits between the control/host bus and the delay-line drive logic; replaces the pass-through sequencer, which has no execution.

Parameters:
DATA_W, 36, operand/output data width; must be >= ADDR_W+LOOP_W
ADDR_W, 9, program address width; depth = 2**ADDR_W words
LOOP_W, 16, width of WAIT cycle count and LOOP repeat count

Ports:
i_clk  in  1  clock; single clock domain
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  start pulse; sampled only in IDLE
i_start_addr  in  ADDR_W  first PC, captured with i_start
i_stop  in  1  abort; returns to IDLE next cycle
o_busy  out  1  high in every non-IDLE state
o_done  out  1  1-cycle pulse when END executes
i_wen  in  1  program write enable
i_wcmd  in  4  command written
i_wdata  in  DATA_W  operand written
i_waddr  in  ADDR_W  write address
o_data  out  DATA_W  last OUT operand, registered, held
o_valid  out  1  1-cycle pulse, coincident with each o_data update

Behaviour:
- Reset (async, i_rst=1): state=IDLE, pc=0, loop_cnt=0, wait_cnt=0, o_busy=0, o_done=0, o_data=0, o_valid=0. RAM contents not reset; they persist across reset.
- RAM: inferred 1 write/1 read synchronous, read latency 1 cycle.
- Writes: accepted only in IDLE. i_wen while busy is ignored and does not change the RAM.
- Read address: pc.
- States: IDLE, FETCH, EXEC, WAIT.
  - IDLE: on i_start, pc<=i_start_addr, loop_cnt<=0, go to FETCH. A start in the same cycle as i_wen is accepted; the write also completes.
  - FETCH: RAM read issued. Always go to EXEC.
  - EXEC: decode rdata command, then act per the command table below.
  - WAIT: decrement wait_cnt; when wait_cnt==1, pc<=pc+1 and go to FETCH.
- Commands in EXEC:
  - 0 NOP: pc<=pc+1, go to FETCH.
  - 1 OUT: o_data<=operand, o_valid<=1 (visible the cycle after EXEC), pc<=pc+1, go to FETCH.
  - 2 WAIT: n=operand[LOOP_W-1:0]. If n==0, behave as NOP. Else wait_cnt<=n, go to WAIT; the instruction occupies exactly n extra cycles.
  - 3 JUMP: pc<=operand[ADDR_W-1:0], go to FETCH.
  - 4 LOOP: target=operand[ADDR_W-1:0], count=operand[ADDR_W+LOOP_W-1:ADDR_W].
    - If loop_cnt<count: loop_cnt++, pc<=target.
    - Else: loop_cnt<=0, pc<=pc+1.
    - Go to FETCH. The body runs count+1 times. Single level only; a nested LOOP shares loop_cnt (undefined program).
  - 5 END: go to IDLE, o_done<=1.
  - 6..15: reserved, executed as NOP.
- Instruction cost: 2 cycles per non-WAIT instruction; OUT-to-OUT spacing is 2 cycles.
- pc arithmetic: modulo 2**ADDR_W; pc wraps from all-ones to 0.
- i_stop in any non-IDLE state: go to IDLE next cycle, o_done stays 0, o_valid stays 0, o_data holds. i_stop has priority over EXEC actions in the same cycle. i_stop in IDLE has no effect.
- i_start while busy: ignored.
- Reset mid-program: immediate return to reset values; program restarts only on a new i_start.

Optional Feature:
X_MICRO_SEQ_TRACE_EN:
- Defined: adds output ports o_pc (ADDR_W, current pc, reset 0) and o_exec (1, pulses 1 cycle after each EXEC cycle, reset 0), plus o_cmd (4, command of the last EXEC, reset 0).
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Load addr0=OUT 0x123, addr1=END; start at 0 -> o_valid pulse with o_data=0x123 on cycle 3 after start; o_done pulse on cycle 5; o_busy low afterwards.
- Load OUT 0xA, WAIT 5, OUT 0xB, END -> the two o_valid pulses are exactly 2+2+5=9 cycles apart.
- Load addr10=OUT 1, addr11=LOOP(target 10, count 3), addr12=END; start_addr=10 -> exactly 4 o_valid pulses, then o_done.
- JUMP wrap: addr511=OUT 7, then pc wraps to 0; addr0=END -> o_data=7, then o_done. Also JUMP to 20 where addr20=END -> o_done.
- Long WAIT 1000; assert i_stop mid-wait -> o_busy low next cycle, no o_done. Write during busy is ignored: read back via a later run to confirm the old value is emitted.
- Assert i_rst mid-OUT sequence -> all outputs 0 asynchronously; after release, re-start reproduces the identical output sequence (RAM retained).
